// File: rtl/vdc_pkg.sv
// Shared slot-action encoding and the fixed grant priority used by the
// VDC RAM slot scheduler.
package vdc_pkg;

  typedef enum logic [2:0] {
    ACT_IDLE = 3'd0,
    ACT_CHAR = 3'd1,
    ACT_SCRN = 3'd2,
    ACT_ATTR = 3'd3,
    ACT_CPU  = 3'd4,
    ACT_RFSH = 3'd5
  } slot_act_t;

  // Columns this close to either end of the line are reserved for the
  // internal (char) path and block SCRN/ATTR/RFSH fetches.
  localparam logic [7:0] INT_MARGIN    = 8'd2;
  localparam logic [8:0] ATTR_LAST_LEN = 9'd2;

  // Highest priority first: CHAR > RFSH > SCRN > ATTR > CPU > IDLE.
  function automatic slot_act_t pick_slot(
    input logic char_ok,
    input logic rfsh_ok,
    input logic scrn_ok,
    input logic attr_ok,
    input logic cpu_ok
  );
    slot_act_t r;
    r = ACT_IDLE;
    if (char_ok)      r = ACT_CHAR;
    else if (rfsh_ok) r = ACT_RFSH;
    else if (scrn_ok) r = ACT_SCRN;
    else if (attr_ok) r = ACT_ATTR;
    else if (cpu_ok)  r = ACT_CPU;
    return r;
  endfunction

endpackage

// File: rtl/vdc_slot_window.sv
// Column-window decode: internal-fetch region at the line edges and the
// refresh window just past the displayed area.
module vdc_slot_window
  import vdc_pkg::*;
(
  input  logic [7:0] col,
  input  logic [7:0] reg_ht,
  input  logic [7:0] reg_hd,
  input  logic [3:0] reg_drr,
  output logic       en_int,
  output logic       en_rfsh
);

  logic [7:0] ht_edge;
  logic [8:0] rfsh_end;

  // 9-bit end-of-window so reg_hd + reg_drr never wraps back into the line.
  always_comb begin
    ht_edge  = (reg_ht >= INT_MARGIN) ? (reg_ht - INT_MARGIN) : 8'd0;
    rfsh_end = {1'b0, reg_hd} + {5'd0, reg_drr};
    en_int   = (col < INT_MARGIN) || (col >= ht_edge);
    en_rfsh  = (col >= reg_hd) && ({1'b0, col} <= rfsh_end);
  end

endmodule

// File: rtl/vdc_ram_sched.sv
// VDC RAM slot scheduler: one arbitrated memory slot per column strobe,
// with screen/attribute latch indexing and a free-running refresh address.
//
//   state  | meaning
//   S_IDLE | no slot outstanding, waiting for newCol
//   S_WAIT | slot granted, waiting for endCol (or abandoned by newCol)
module vdc_ram_sched
  import vdc_pkg::*;
#(
  parameter int S_LATCH_WIDTH = 80,
  parameter int S_LATCH_BITS  = $clog2(S_LATCH_WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    newCol,
  input  logic                    endCol,
  input  logic [7:0]              col,
  input  logic [7:0]              reg_ht,
  input  logic [7:0]              reg_hd,
  input  logic [3:0]              reg_drr,
  input  logic                    rowStart,
  input  logic                    lastRow,
  input  logic                    char_req,
  input  logic                    scrn_en,
  input  logic                    attr_en,
  input  logic                    cpu_req,
  output logic                    cpu_ack,
  output logic [2:0]              slot_act,
  output logic [S_LATCH_BITS-1:0] slot_idx,
  output logic [7:0]              rfsh_addr,
  output logic                    issue,
  output logic                    done,
  output logic                    busy
);

  // Counters need one extra bit to hold the full-latch value itself.
  localparam int         CW       = S_LATCH_BITS + 1;
  localparam logic [8:0] LATCH_W9 = 9'(S_LATCH_WIDTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t    state;
  slot_act_t act_q;
  logic [CW-1:0] si, ai;

  logic en_int, en_rfsh;

  vdc_slot_window u_window (
    .col     (col),
    .reg_ht  (reg_ht),
    .reg_hd  (reg_hd),
    .reg_drr (reg_drr),
    .en_int  (en_int),
    .en_rfsh (en_rfsh)
  );

  logic                    newcol_eff;
  logic                    row_clr;
  logic [CW-1:0]           si_eff, ai_eff;
  logic [8:0]              scrnlen, attrlen;
  logic                    scrn_ok, attr_ok;
  slot_act_t               grant;
  logic [S_LATCH_BITS-1:0] grant_idx;

  // endCol wins over a coincident newCol; the row clear is seen by this
  // cycle's arbitration.
  always_comb begin
    newcol_eff = newCol && !endCol;
    row_clr    = newcol_eff && rowStart && (col == 8'd0);
    si_eff     = row_clr ? '0 : si;
    ai_eff     = row_clr ? '0 : ai;
    scrnlen    = ({1'b0, reg_hd} > LATCH_W9) ? LATCH_W9 : {1'b0, reg_hd};
    attrlen    = lastRow ? ATTR_LAST_LEN : scrnlen;
    scrn_ok    = scrn_en && !en_int && (32'(si_eff) < 32'(scrnlen));
    attr_ok    = attr_en && !en_int && (32'(ai_eff) < 32'(attrlen));
    grant      = pick_slot(char_req, !en_int && en_rfsh, scrn_ok, attr_ok, cpu_req);
    grant_idx  = '0;
    if (grant == ACT_SCRN)      grant_idx = si_eff[S_LATCH_BITS-1:0];
    else if (grant == ACT_ATTR) grant_idx = ai_eff[S_LATCH_BITS-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      act_q     <= ACT_IDLE;
      slot_idx  <= '0;
      rfsh_addr <= 8'd0;
      si        <= '0;
      ai        <= '0;
      issue     <= 1'b0;
      done      <= 1'b0;
      cpu_ack   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      issue   <= 1'b0;
      done    <= 1'b0;
      cpu_ack <= 1'b0;
      if (enable) begin
        if (row_clr) begin
          si <= '0;
          ai <= '0;
        end
        if (state == S_WAIT && endCol) begin
          state    <= S_IDLE;
          done     <= 1'b1;
          cpu_ack  <= (act_q == ACT_CPU);
          busy     <= 1'b0;
          act_q    <= ACT_IDLE;
          slot_idx <= '0;
          if (act_q == ACT_SCRN) si <= si + CW'(1);
          if (act_q == ACT_ATTR) ai <= ai + CW'(1);
        end else if (newcol_eff) begin
          // Launch from idle, or abandon the outstanding slot and re-grant.
          state    <= S_WAIT;
          issue    <= 1'b1;
          busy     <= 1'b1;
          act_q    <= grant;
          slot_idx <= grant_idx;
          if (grant == ACT_RFSH) rfsh_addr <= rfsh_addr + 8'd1;
        end
      end
    end
  end

  assign slot_act = act_q;

endmodule

// File: doc/vdc_ram_sched.md
VDC_RAM_SCHED -- requirements
Module: vdc_ram_sched

Interface
REQ-001 SHALL have parameter S_LATCH_WIDTH, default 80, giving the depth of the screen/attribute latch and the maximum per-row fetch count.
REQ-002 SHALL have parameter S_LATCH_BITS, default $clog2(S_LATCH_WIDTH), giving the index width.
REQ-003 SHALL use one clock and an asynchronous active-low reset.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  clock enable; no state changes while low.
REQ-007 newCol / endCol  in  1 each  column slot start / end strobes.
REQ-008 col  in  8  current character column.
REQ-009 reg_ht, reg_hd  in  8 each  horizontal total / horizontal displayed.
REQ-010 reg_drr  in  4  refresh slots per line.
REQ-011 rowStart, lastRow  in  1 each  new fetch row (valid with col==0) / final row.
REQ-012 char_req, scrn_en, attr_en  in  1 each  char fetch wanted / screen fetch enabled (bitmap) / attribute fetch enabled.
REQ-013 cpu_req  in  1  CPU port access pending (level).
REQ-014 cpu_ack  out  1  one-cycle pulse when a CPU slot completes.
REQ-015 slot_act  out  3  granted action, enum {IDLE, CHAR, SCRN, ATTR, CPU, RFSH}.
REQ-016 slot_idx  out  S_LATCH_BITS  latch index for SCRN/ATTR slots; otherwise 0.
REQ-017 rfsh_addr  out  8  refresh row address.
REQ-018 issue, done  out  1 each  one-cycle pulses at grant / completion.
REQ-019 busy  out  1  high while a slot is outstanding.

Function
REQ-020 SHALL implement states S_IDLE and S_WAIT; issue asserts on the S_IDLE->S_WAIT transition, taken on enable&&newCol.
REQ-021 SHALL leave S_WAIT for S_IDLE on enable&&endCol and assert done in that cycle.
REQ-022 SHALL grant by fixed priority: CHAR (char_req) > RFSH (!en_int&&en_rfsh) > SCRN (scrn_en&&!en_int&&si<scrnlen) > ATTR (attr_en&&!en_int&&ai<attrlen) > CPU (cpu_req) > IDLE.
REQ-023 SHALL compute en_int = col<2 || col>=reg_ht-2, where the subtraction saturates at 0.
REQ-024 SHALL compute en_rfsh = col>=reg_hd && col<=reg_hd+reg_drr using 9-bit arithmetic, so there is no wrap.
REQ-025 SHALL set scrnlen = min(reg_hd, S_LATCH_WIDTH), and attrlen = lastRow ? 2 : scrnlen.
REQ-026 SHALL clear si and ai on rowStart&&newCol&&col==0, before arbitration in the same cycle.
REQ-027 SHALL increment si/ai at done of a SCRN/ATTR slot; slot_idx holds the pre-increment value for the whole slot.
REQ-028 SHALL increment rfsh_addr by 1 at each RFSH grant, wrapping 0xFF->0x00.
REQ-029 SHALL pulse cpu_ack with done for a CPU slot, even if cpu_req dropped mid-slot.
REQ-030 SHALL hold slot_act stable from issue through done, then return it to IDLE.
REQ-031 On simultaneous endCol and newCol, endCol SHALL be processed and newCol dropped.
REQ-032 On newCol in S_WAIT without endCol, the scheduler SHALL abandon the outstanding slot (no done, no ack, no index increment) and re-arbitrate.
REQ-033 When enable is low, the scheduler SHALL ignore strobes and freeze all state.

Reset
REQ-034 reset_n low SHALL asynchronously force S_IDLE, slot_act=IDLE, slot_idx=0, rfsh_addr=0, si=ai=0, and issue=done=cpu_ack=busy=0.
REQ-035 A reset mid-slot SHALL discard the slot without an ack.
REQ-036 Release of reset SHALL be synchronous to clk.

Structure
REQ-037 The slot_act enum and the priority order SHALL live in a shared package, vdc_pkg.
REQ-038 An optional sub-module vdc_slot_window SHALL hold the combinational en_int/en_rfsh window logic.
REQ-039 The scheduler state machine and counters SHALL be in vdc_ram_sched itself.

Verification
REQ-040 Priority: reg_ht=126, reg_hd=80, reg_drr=5, col=82, cpu_req=1, scrn_en=1 -> slot_act=RFSH, rfsh_addr increments.
REQ-041 Screen fill: rowStart at col 0, scrn_en=1, reg_hd=80 -> exactly 80 SCRN slots in idx 0..79, none after.
REQ-042 lastRow=1, attr_en=1 -> exactly 2 ATTR slots per row.
REQ-043 CPU: cpu_req held, char_req=0, col=3 outside the refresh window, si=scrnlen -> CPU grant; cpu_ack pulses with done.
REQ-044 Boundaries: endCol with newCol in the same cycle -> no new issue; rfsh_addr 0xFF -> 0x00; reg_ht=1 -> en_int true for all columns.
REQ-045 reset_n asserted in S_WAIT with slot_act=CPU -> immediate IDLE, no cpu_ack, busy=0.
